// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and helpers for the instruction fetch stage
package instruction_fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

   // Fetch FSM encoding; kept as plain constants so legacy decode tables stay valid.
   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   // Sequential successor of a fetch address; wraps naturally at 2^XLEN.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + INSTR_BYTES;
   endfunction

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage with IF/ID register; FETCH_MISALIGN_CHECK_EN enables misaligned-redirect fault
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] instruction_address,
   input  logic [XLEN-1:0] instruction,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   input  logic            id_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt_req,
   output logic            fetch_fault,
   output logic [XLEN-1:0] fetch_count
);

   logic [1:0]      state;
   logic [XLEN-1:0] pc;
   logic            transfer;
   logic            fault_q;
   logic [XLEN-1:0] redirect_target;
   logic            redirect_bad;

   assign instruction_address = pc;
   assign transfer            = id_valid && id_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redirect_target = redirect_pc;
   assign redirect_bad    = (redirect_pc[1:0] != 2'b00);
   assign fetch_fault     = fault_q;
`else
   // Without the check, low address bits are simply dropped and no fault is ever raised.
   assign redirect_target = redirect_pc & ~32'd3;
   assign redirect_bad    = 1'b0;
   assign fetch_fault     = 1'b0;
`endif

   // Completed decode handshakes are counted in every state, including on redirect cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (transfer) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end

   // Fetch FSM, pc and IF/ID register; redirect outranks halt and sequential fetch outside BOOT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_BOOT;
         pc       <= RESET_PC;
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
         fault_q  <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state <= ST_RUN;
            end
            default: begin
               if (redirect_valid) begin
                  id_valid <= 1'b0;
                  if (redirect_bad) begin
                     fault_q <= 1'b1;
                     state   <= ST_HALT;
                  end else begin
                     fault_q <= 1'b0;
                     pc      <= redirect_target;
                     state   <= ST_RUN;
                  end
               end else if (state == ST_RUN && !halt_req) begin
                  if (!id_valid || id_ready) begin
                     id_instr <= instruction;
                     id_pc    <= pc;
                     id_valid <= 1'b1;
                     pc       <= next_pc(pc);
                  end
               end else begin
                  // Halting (or halted): drain the held entry, load nothing new.
                  if (state == ST_RUN) begin
                     state <= ST_HALT;
                  end
                  if (transfer) begin
                     id_valid <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC SHALL be supported: default 32'h0000_0000; byte address of the first fetch.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 instruction_address  output  32  byte address presented to instruction memory; SHALL equal the internal pc register, combinationally.
REQ-005 instruction  input  32  memory read data, valid in the same cycle as instruction_address.
REQ-006 id_valid  output  1  IF/ID register holds an instruction.
REQ-007 id_instr  output  32  instruction for decode.
REQ-008 id_pc  output  32  address of id_instr.
REQ-009 id_ready  input  1  decode accepts; a transfer occurs when id_valid && id_ready.
REQ-010 redirect_valid  input  1  branch/jump redirect request.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 halt_req  input  1  stop fetching.
REQ-013 fetch_fault  output  1  misaligned redirect detected; sticky until redirect or reset.
REQ-014 fetch_count  output  32  number of completed transfers.

Function
REQ-015 FSM states SHALL be BOOT, RUN, HALT; reset enters BOOT; BOOT -> RUN unconditionally after one edge, no fetch in BOOT.
REQ-016 In RUN, when (!id_valid || id_ready) and !redirect_valid: id_instr <= instruction, id_pc <= pc, id_valid <= 1, pc <= pc + 4 (modulo 2^32, wraps FFFF_FFFC -> 0000_0000).
REQ-017 In RUN, when id_valid && !id_ready: id_* and pc SHALL hold (stall).
REQ-018 In RUN, when (!id_valid || id_ready) fails to load because the state is not RUN, id_valid SHALL clear on a completed transfer.
REQ-019 redirect_valid SHALL have highest priority in any state except BOOT: pc <= redirect_pc, id_valid <= 0, state <= RUN, fetch_fault <= 0; a transfer completing the same cycle SHALL still count.
REQ-020 First instruction from redirect_pc SHALL appear on id_* one edge after the redirect edge.
REQ-021 halt_req in RUN (without redirect) SHALL move to HALT; the current id_* entry SHALL remain until transferred; no new loads in HALT; pc frozen.
REQ-022 HALT SHALL exit only on redirect_valid or reset.
REQ-023 fetch_count SHALL increment by 1 per transfer, wrapping at 2^32.
REQ-024 Redirect and halt_req simultaneous: redirect wins, state RUN.

Reset
REQ-025 On rst_n low: pc = RESET_PC, state BOOT, id_valid = 0, id_instr = 0, id_pc = 0, fetch_fault = 0, fetch_count = 0; reset mid-stall discards the held entry.
REQ-026 instruction_address SHALL equal RESET_PC during and immediately after reset.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 SHALL set fetch_fault, clear id_valid, enter HALT, leave pc unchanged.
REQ-028 Macro undefined: redirect_pc[1:0] SHALL be forced to 2'b00; fetch_fault SHALL be tied 0.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), XLEN=32 and INSTR_BYTES=4.
REQ-030 Single module; no sub-module; instantiated together with instruction_mem, whose instruction_address/instruction ports it drives and reads.

Verification
REQ-031 Reset release, id_ready=1, memory holds word i at address 4i -> id_pc 0,4,8 on edges 2,3,4; id_valid first high after edge 2.
REQ-032 id_ready=0 for 3 cycles with id_pc=8 -> id_pc, id_instr, instruction_address=12 hold; fetch_count unchanged; resume -> id_pc 12 next.
REQ-033 redirect_valid with redirect_pc=0x40 while id_valid && id_ready -> fetch_count +1, id_valid=0 next edge, id_pc=0x40 edge after.
REQ-034 halt_req at pc=0x10 with id_ready=0 -> HALT, entry held, accepted when id_ready=1, then id_valid=0 and instruction_address stays 0x10; redirect 0x0 -> RUN.
REQ-035 With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x42 -> fetch_fault=1, HALT; redirect 0x44 -> fetch_fault=0, id_pc=0x44. Without macro: id_pc=0x40.
REQ-036 Assert rst_n low mid-stall -> all outputs at reset values asynchronously, instruction_address=RESET_PC.
